config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Programs the serial configuration chain of a cascade of ALU/DSP tiles (configuration_input / configuration_enable / configuration_output daisy-chain).
- Accepts a parallel configuration word over a valid/ready handshake and shifts it bit-serially into the chain.
- Raises busy while shifting so upstream control can hold the datapath idle.
- Sits between the host/config register file and the first tile's configuration_input.

Parameters:
- CHAIN_LEN, 2, total configuration bits in the chain (2 = one ALU's SIMD-mode bits); legal range 1..1024.
- CNT_W, $clog2(CHAIN_LEN+1), shift-counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; chain tiles share it.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  load request.
- load_ready  out  1  high only in IDLE.
- load_data  in  CHAIN_LEN  word to program; bit CHAIN_LEN-1 lands in the chain's last (deepest) flop.
- cfg_abort  in  1  synchronous abort of an in-progress shift.
- configuration_output  in  1  serial bit returning from the chain's tail.
- configuration_input  out  1  serial bit to the chain head.
- configuration_enable  out  1  chain shift enable.
- cfg_busy  out  1  high in SHIFT.
- cfg_done  out  1  one-cycle pulse on successful completion.
- cfg_aborted  out  1  one-cycle pulse on abort.
- rb_data  out  CHAIN_LEN  previous chain contents; present only with CFG_READBACK_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0 except load_ready=1; shift register and counter cleared. Chain tile contents are not reset by this block and are undefined until the first full load.
- All outputs are registered.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - On load_valid && load_ready at edge N: latch load_data into the shift register, set cnt=0, go to SHIFT.
- SHIFT:
  - configuration_enable=1 and configuration_input=shreg[CHAIN_LEN-1] (MSB first) for exactly cycles N+1..N+CHAIN_LEN.
  - Each edge shifts shreg left by one and increments cnt.
  - When cnt reaches CHAIN_LEN-1 at an edge, go to DONE.
  - load_ready=0 and load_valid is ignored.
- DONE:
  - One cycle with cfg_done=1, configuration_enable=0, cfg_busy=0.
  - Unconditional return to IDLE; load_ready returns at cycle N+CHAIN_LEN+2.
- Abort:
  - cfg_abort sampled high in SHIFT goes to IDLE at the next edge.
  - configuration_enable drops that same edge; cfg_aborted pulses 1 cycle; no cfg_done.
  - Chain left partially shifted (undefined config).
  - cfg_abort is ignored in IDLE and DONE.
- Simultaneous cfg_abort and the last shift cycle: abort wins; cfg_aborted pulses and cfg_done does not.
- Back-to-back loads: minimum spacing between accepts is CHAIN_LEN+2 cycles. load_valid held high across DONE is accepted on the first IDLE cycle.
- Reset asserted mid-SHIFT: immediate return to IDLE with enable low; the chain holds whatever partial state it had.
- Bit ordering: after completion, chain flop k (k=0 nearest head) holds load_data[k].
- Throughput: one bit per cycle; no wait states.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined:
  - During SHIFT, each cycle samples configuration_output into rb shift register LSB (shift left), capturing the previous chain contents MSB-first.
  - rb_data is updated to the captured word at the DONE cycle and holds until the next DONE.
  - rb_data resets to 0 and is not updated on abort.
- Undefined: rb_data port and logic absent; configuration_output port remains present but unused.

Decomposition:
- Package config_chain_pkg:
  - cfg_state_t enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - SIMD mode localparams ONE48=2'b00, TWO24=2'b01, FOUR12=2'b10 for bench and host use.
- No sub-module required. The shift/readback register pair may optionally be split into config_shift_reg (parallel-load, serial-out, serial-in).

Test Plan:
- CHAIN_LEN=2, driving one ALU tile: load 2'b01 → configuration_enable high for exactly 2 cycles, configuration_input sequence 0,1, cfg_done pulse on cycle 3, tile USE_SIMD=TWO24.
- Load 2'b10 then 2'b00 back-to-back with load_valid held high → second accept exactly 4 cycles after the first, final mode ONE48, two cfg_done pulses.
- CHAIN_LEN=8, load 8'hA5, assert cfg_abort during the 4th shift cycle → enable low next edge, cfg_aborted=1 for 1 cycle, no cfg_done, load_ready=1 the following cycle.
- Assert rst_n=0 asynchronously mid-SHIFT → load_ready=1 and configuration_enable=0 without waiting for a clk edge; a new load after release completes normally.
- CFG_READBACK_EN, CHAIN_LEN=8, with a behavioural 8-flop chain: load 8'h3C, then load 8'hC3 → rb_data=8'h3C at the second DONE.
- cfg_abort coincident with the final shift cycle → cfg_aborted pulses, cfg_done stays 0, rb_data unchanged.

Source files
------------

// File: rtl/config_chain_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and the
// SIMD mode codes a two-bit ALU tile configuration word takes.
package config_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cfg_state_t;

    localparam logic [1:0] ONE48  = 2'b00;
    localparam logic [1:0] TWO24  = 2'b01;
    localparam logic [1:0] FOUR12 = 2'b10;

endpackage

// File: rtl/config_chain_loader.sv
// Loads a parallel word bit-serially (MSB first) into a tile configuration chain.
// Optional CFG_READBACK_EN captures the chain's previous contents from its tail into rb_data.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 2,
    localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 cfg_abort,
    input  logic                 configuration_output,
    output logic                 configuration_input,
    output logic                 configuration_enable,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 cfg_aborted
`ifdef CFG_READBACK_EN
    ,
    output logic [CHAIN_LEN-1:0] rb_data
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    cfg_state_t           state_q, state_d;
    logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 en_q, en_d;
    logic                 in_q, in_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;

`ifdef CFG_READBACK_EN
    logic [CHAIN_LEN-1:0] rb_sh_q, rb_sh_d;
    logic [CHAIN_LEN-1:0] rb_data_q, rb_data_d;
    logic [CHAIN_LEN:0]   rb_cat;
`else
    logic                 cfg_out_unused;
    assign cfg_out_unused = configuration_output;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        en_d      = en_q;
        in_d      = in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
`ifdef CFG_READBACK_EN
        rb_sh_d   = rb_sh_q;
        rb_data_d = rb_data_q;
        // Concatenate then truncate so a one-bit chain needs no special case.
        rb_cat    = {rb_sh_q, configuration_output};
`endif
        case (state_q)
            IDLE: begin
                if (load_valid && ready_q) begin
                    // The MSB goes out on the very first enabled cycle, so it
                    // is peeled off here and the rest is pre-shifted.
                    in_d    = load_data[CHAIN_LEN-1];
                    shreg_d = load_data << 1;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = SHIFT;
`ifdef CFG_READBACK_EN
                    rb_sh_d = '0;
`endif
                end
            end
            SHIFT: begin
`ifdef CFG_READBACK_EN
                rb_sh_d = rb_cat[CHAIN_LEN-1:0];
`endif
                if (cfg_abort) begin
                    state_d   = IDLE;
                    en_d      = 1'b0;
                    in_d      = 1'b0;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                    aborted_d = 1'b1;
                    cnt_d     = '0;
                    shreg_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                    in_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
`ifdef CFG_READBACK_EN
                    rb_data_d = rb_cat[CHAIN_LEN-1:0];
`endif
                end else begin
                    in_d    = shreg_q[CHAIN_LEN-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                en_d    = 1'b0;
                in_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            en_q      <= 1'b0;
            in_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            en_q      <= en_d;
            in_q      <= in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

`ifdef CFG_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_sh_q   <= '0;
            rb_data_q <= '0;
        end else begin
            rb_sh_q   <= rb_sh_d;
            rb_data_q <= rb_data_d;
        end
    end

    assign rb_data = rb_data_q;
`endif

    assign load_ready           = ready_q;
    assign configuration_input  = in_q;
    assign configuration_enable = en_q;
    assign cfg_busy             = busy_q;
    assign cfg_done             = done_q;
    assign cfg_aborted          = aborted_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 2-bit (one ALU tile) and an 8-bit chain, each
// with a behavioural shift chain; rb_data is checked when CFG_READBACK_EN is defined.
module tb_config_chain_loader;
    import config_chain_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v2 = 1'b0, ab2 = 1'b0;
    logic [1:0] d2 = '0;
    logic       ready2, in2, en2, busy2, done2, abd2;
    logic [1:0] chain2 = '0;

    logic       v8 = 1'b0, ab8 = 1'b0;
    logic [7:0] d8 = '0;
    logic       ready8, in8, en8, busy8, done8, abd8;
    logic [7:0] chain8 = '0;
`ifdef CFG_READBACK_EN
    logic [1:0] rb2;
    logic [7:0] rb8;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_t[2];

    always #5 clk = ~clk;

    config_chain_loader #(.CHAIN_LEN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .load_valid(v2), .load_ready(ready2),
        .load_data(d2), .cfg_abort(ab2), .configuration_output(chain2[1]),
        .configuration_input(in2), .configuration_enable(en2),
        .cfg_busy(busy2), .cfg_done(done2), .cfg_aborted(abd2)
`ifdef CFG_READBACK_EN
        , .rb_data(rb2)
`endif
    );

    config_chain_loader #(.CHAIN_LEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .load_valid(v8), .load_ready(ready8),
        .load_data(d8), .cfg_abort(ab8), .configuration_output(chain8[7]),
        .configuration_input(in8), .configuration_enable(en8),
        .cfg_busy(busy8), .cfg_done(done8), .cfg_aborted(abd8)
`ifdef CFG_READBACK_EN
        , .rb_data(rb8)
`endif
    );

    // Tile chains: flop 0 is nearest the head, the tail feeds configuration_output.
    always @(posedge clk) begin
        if (en2) chain2 <= {chain2[0], in2};
        if (en8) chain8 <= {chain8[6:0], in8};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (v2 && ready2) begin
            if (acc_n < 2) acc_t[acc_n] <= cyc;
            acc_n <= acc_n + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_load2(input logic [1:0] d);
        int n;
        @(negedge clk);
        v2 = 1'b1;
        d2 = d;
        n = 0;
        while (ready2 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready2_wait", {31'd0, ready2}, 32'd1);
        @(negedge clk);
        v2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("en2_shift", {31'd0, en2}, 32'd1);
            chk("in2_bit", {31'd0, in2}, {31'd0, d[1-i]});
            chk("busy2_shift", {31'd0, busy2}, 32'd1);
            chk("ready2_shift", {31'd0, ready2}, 32'd0);
            chk("done2_early", {31'd0, done2}, 32'd0);
            @(negedge clk);
        end
        chk("done2_pulse", {31'd0, done2}, 32'd1);
        chk("en2_done", {31'd0, en2}, 32'd0);
        chk("busy2_done", {31'd0, busy2}, 32'd0);
        chk("ready2_done", {31'd0, ready2}, 32'd0);
        @(negedge clk);
        chk("ready2_back", {31'd0, ready2}, 32'd1);
        chk("done2_once", {31'd0, done2}, 32'd0);
        $display("load2 data=%b chain=%b", d, chain2);
    endtask

    task automatic run_load8(input logic [7:0] d, input bit check_rb, input logic [7:0] exp_rb);
        int n;
        @(negedge clk);
        v8 = 1'b1;
        d8 = d;
        n = 0;
        while (ready8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready8_wait", {31'd0, ready8}, 32'd1);
        @(negedge clk);
        v8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("en8_shift", {31'd0, en8}, 32'd1);
            chk("in8_bit", {31'd0, in8}, {31'd0, d[7-i]});
            chk("busy8_shift", {31'd0, busy8}, 32'd1);
            @(negedge clk);
        end
        chk("done8_pulse", {31'd0, done8}, 32'd1);
        chk("en8_done", {31'd0, en8}, 32'd0);
`ifdef CFG_READBACK_EN
        if (check_rb) chk("rb8_done", {24'd0, rb8}, {24'd0, exp_rb});
`endif
        @(negedge clk);
        chk("ready8_back", {31'd0, ready8}, 32'd1);
        chk("chain8_value", {24'd0, chain8}, {24'd0, d});
        $display("load8 data=%h chain=%h rb_chk=%0d exp_rb=%h", d, chain8, check_rb, exp_rb);
    endtask

    task automatic abort8(input logic [7:0] d, input int at_cycle);
        int n;
        @(negedge clk);
        v8 = 1'b1;
        d8 = d;
        n = 0;
        while (ready8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready8_wait_ab", {31'd0, ready8}, 32'd1);
        @(negedge clk);
        v8 = 1'b0;
        chk("en8_first", {31'd0, en8}, 32'd1);
        chk("in8_first", {31'd0, in8}, {31'd0, d[7]});
        repeat (at_cycle - 1) @(negedge clk);
        chk("en8_before_abort", {31'd0, en8}, 32'd1);
        ab8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0;
        chk("en8_after_abort", {31'd0, en8}, 32'd0);
        chk("aborted8_pulse", {31'd0, abd8}, 32'd1);
        chk("done8_on_abort", {31'd0, done8}, 32'd0);
        chk("ready8_after_abort", {31'd0, ready8}, 32'd1);
        chk("busy8_after_abort", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        chk("aborted8_once", {31'd0, abd8}, 32'd0);
        chk("done8_late", {31'd0, done8}, 32'd0);
        $display("abort8 data=%h at shift cycle %0d", d, at_cycle);
    endtask

    typedef struct {
        logic [1:0] data;
        logic [1:0] exp_mode;
    } vec2_t;

    vec2_t tbl[4];

    initial begin
        int n;
        int dn;
        tbl[0] = '{data: 2'b01, exp_mode: TWO24};
        tbl[1] = '{data: 2'b10, exp_mode: FOUR12};
        tbl[2] = '{data: 2'b11, exp_mode: 2'b11};
        tbl[3] = '{data: 2'b00, exp_mode: ONE48};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready2", {31'd0, ready2}, 32'd1);
        chk("rst_en2", {31'd0, en2}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        chk("rst_done2", {31'd0, done2}, 32'd0);
        chk("rst_abd2", {31'd0, abd2}, 32'd0);
        chk("rst_in2", {31'd0, in2}, 32'd0);
        chk("rst_ready8", {31'd0, ready8}, 32'd1);
        chk("rst_en8", {31'd0, en8}, 32'd0);
`ifdef CFG_READBACK_EN
        chk("rst_rb8", {24'd0, rb8}, 32'd0);
`endif

        for (int i = 0; i < 4; i++) begin
            run_load2(tbl[i].data);
            chk("tile_mode", {30'd0, chain2}, {30'd0, tbl[i].exp_mode});
        end

        // Back-to-back: valid held high, data switched after the first accept.
        @(negedge clk);
        acc_n = 0;
        v2 = 1'b1;
        d2 = 2'b10;
        @(negedge clk);
        d2 = 2'b00;
        dn = 0;
        n = 0;
        while (dn < 2 && n < 30) begin
            @(negedge clk);
            if (done2) dn++;
            n++;
        end
        v2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done_count", dn, 32'd2);
        chk("b2b_accepts", acc_n, 32'd2);
        chk("b2b_spacing", acc_t[1] - acc_t[0], 32'd4);
        chk("b2b_mode", {30'd0, chain2}, {30'd0, ONE48});
        $display("back-to-back accepts at %0d and %0d, mode=%b", acc_t[0], acc_t[1], chain2);

        run_load8(8'hA5, 1'b1, 8'h00);
        abort8(8'hA5, 4);
        run_load8(8'h3C, 1'b0, 8'h00);
        run_load8(8'hC3, 1'b1, 8'h3C);
        chk("chain8_c3", {24'd0, chain8}, 32'hC3);

        // Abort coincident with the final shift cycle.
        abort8(8'h5A, 8);
`ifdef CFG_READBACK_EN
        chk("rb8_after_abort", {24'd0, rb8}, 32'h3C);
`endif

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        v8 = 1'b1;
        d8 = 8'hFF;
        @(negedge clk);
        v8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("en8_pre_reset", {31'd0, en8}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ready8", {31'd0, ready8}, 32'd1);
        chk("async_en8", {31'd0, en8}, 32'd0);
        chk("async_busy8", {31'd0, busy8}, 32'd0);
`ifdef CFG_READBACK_EN
        chk("async_rb8", {24'd0, rb8}, 32'd0);
`endif
        $display("async reset asserted mid-shift at t=%0t", $time);
        @(negedge clk);
        rst_n = 1'b1;
        run_load8(8'h96, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
